// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: stall/flush control,
// E-stage forwarding selects, memory-wait watchdog and saturating event counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWE,
   input  logic             RegWM,
   input  logic             RegWW,
   input  logic             MemToRegE,
   input  logic             BranchTakenE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             memErr,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ERR_FLUSH
   } state_t;

   state_t            state_reg;
   logic [WC_W-1:0]   wait_cnt_reg;
   logic              mem_stall;
   logic              load_use;

   logic [4:0]        fwd_src [2];
   logic [1:0]        fwd_sel [2];

   assign fwd_src[0] = RsE;
   assign fwd_src[1] = RtE;

   // M-stage result is newer than W, so it wins when both match.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic hit_m;
         logic hit_w;
         assign hit_m = RegWM && (WriteRegM != 5'd0) && (WriteRegM == fwd_src[gi]);
         assign hit_w = RegWW && (WriteRegW != 5'd0) && (WriteRegW == fwd_src[gi]);
         assign fwd_sel[gi] = reset ? 2'b00 :
                              hit_m ? 2'b10 :
                              hit_w ? 2'b01 : 2'b00;
      end
   endgenerate

   assign ForwardAE = fwd_sel[0];
   assign ForwardBE = fwd_sel[1];

   assign mem_stall = MemReqM && !MemReadyM;
   assign load_use  = MemToRegE && RegWE && (WriteRegE != 5'd0) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushW = 1'b0;
      if (reset || (state_reg == ERR_FLUSH)) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushW = 1'b1;
      end else if (mem_stall) begin
         // Freeze the whole pipe; W is bubbled so the held M result is not retired twice.
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (BranchTakenE) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (load_use) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= RUN;
         wait_cnt_reg <= '0;
         memErr       <= 1'b0;
      end else begin
         memErr <= 1'b0;
         case (state_reg)
            RUN: begin
               if (mem_stall) begin
                  state_reg    <= MEM_WAIT;
                  wait_cnt_reg <= WC_W'(1);
               end
            end
            MEM_WAIT: begin
               // A dropped request releases the pipe just like a completion.
               if (!mem_stall) begin
                  state_reg    <= RUN;
                  wait_cnt_reg <= '0;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  state_reg    <= ERR_FLUSH;
                  wait_cnt_reg <= '0;
                  memErr       <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
               end
            end
            ERR_FLUSH: begin
               state_reg    <= RUN;
               wait_cnt_reg <= '0;
            end
            default: begin
               state_reg    <= RUN;
               wait_cnt_reg <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stallF && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + CNT_W'(1);
         if (flushE && (flushCnt != {CNT_W{1'b1}}))
            flushCnt <= flushCnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall and flush controls for the F/D/E/M pipeline registers, including flushE into the ID/EX register, and the E-stage forwarding selects.
- Stalls the whole pipe on multi-cycle data-memory accesses, with a watchdog timeout.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before an error abort (>=2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- RsD, RtD  input  5  source registers in D
- RsE, RtE  input  5  source registers in E
- WriteRegE, WriteRegM, WriteRegW  input  5  destination registers per stage
- RegWE, RegWM, RegWW  input  1  register-write enables per stage
- MemToRegE  input  1  instruction in E is a load
- BranchTakenE  input  1  branch/jump resolved taken in E
- MemReqM  input  1  M stage issues a data-memory access
- MemReadyM  input  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  output  1  hold the respective pipeline register
- flushD, flushE, flushW  output  1  bubble the respective pipeline register
- ForwardAE, ForwardBE  output  2  00 = regfile, 10 = from M, 01 = from W
- memErr  output  1  one-cycle pulse on memory timeout
- stallCnt, flushCnt  output  CNT_W  saturating event counters

Behaviour:
- States: RUN, MEM_WAIT, ERR_FLUSH. Encoding is free.
- Reset: state=RUN, waitCnt=0, stallCnt=0, flushCnt=0, memErr=0. On the reset cycle all stall outputs are 0, flushD/E/W=1, ForwardAE/BE=00.
- Forwarding (combinational, every state), shown for A; B is identical with RtE:
  - 10 if RegWM && WriteRegM!=0 && WriteRegM==RsE;
  - else 01 if RegWW && WriteRegW!=0 && WriteRegW==RsE;
  - else 00.
  - M has priority over W.
- memStall = MemReqM && !MemReadyM.
- Control outputs are combinational from state and inputs. Priority: reset > ERR_FLUSH > memStall (RUN or MEM_WAIT) > BranchTakenE > load-use. Unlisted outputs are 0.
- ERR_FLUSH: flushD=flushE=flushW=1, no stalls. Next state is RUN.
- memStall: stallF=stallD=stallE=stallM=1, flushW=1. Branch and load-use are ignored this cycle and re-evaluated when the stall clears.
- BranchTakenE (no memStall): flushD=flushE=1. This gives a 2-bubble penalty and overrides load-use.
- Load-use: MemToRegE && RegWE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD).
  - stallF=stallD=1, flushE=1.
  - Exactly one bubble; the value is then forwarded from W.
- Transitions:
  - RUN -> MEM_WAIT when memStall; waitCnt<=1.
  - MemReqM && MemReadyM in the same cycle stays in RUN with no stall.
  - MEM_WAIT: if MemReadyM, go to RUN, waitCnt<=0. Otherwise:
    - if waitCnt==MEM_TIMEOUT-1, go to ERR_FLUSH, memErr<=1, waitCnt<=0;
    - else waitCnt<=waitCnt+1.
  - MemReqM dropping in MEM_WAIT is treated as ready: go to RUN.
  - memErr is high for exactly the ERR_FLUSH cycle.
- Counters:
  - stallCnt += 1 on each cycle where stallF=1.
  - flushCnt += 1 on each cycle where flushE=1.
  - Both saturate at all-ones, hold, and clear only on reset.
- Reset mid-MEM_WAIT: the next cycle is RUN with counters at 0, regardless of MemReadyM.

Test Plan:
- Forwarding: RsE=5, RegWM=1, WriteRegM=5, RegWW=1, WriteRegW=5 -> ForwardAE=10. Set WriteRegM=0 -> ForwardAE=01. Set RsE=0 with writes to reg 0 -> ForwardAE=00.
- Load-use: MemToRegE=1, RegWE=1, WriteRegE=8, RtD=8 -> one cycle of stallF=stallD=flushE=1. stallCnt=1, flushCnt=1.
- Branch plus load-use in the same cycle -> flushD=flushE=1, stallF=0.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high -> stallF/D/E/M=1 and flushW=1 for 3 cycles, then RUN. stallCnt=3, no memErr. MemReqM=MemReadyM=1 together -> no stall.
- Timeout with MEM_TIMEOUT=4: MemReadyM held low -> 4 stall cycles, then 1 cycle of ERR_FLUSH (memErr=1, flushD/E/W=1), then RUN.
- Reset asserted in the 2nd MEM_WAIT cycle -> next cycle stalls=0, stallCnt=0, state RUN. Saturation with CNT_W=4: 20 load-use events -> stallCnt=15.
